// File: rtl/rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rf_pkg                                                            |
// | Desc   : Shared register-file widths and writeback entry type.             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wb_fifo                                                           |
// | Desc   : Multi-cycle result FIFO with per-entry kill-by-address and a      |
// |          pending-destination bitmap over live entries.                     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_ADDR_W,
  parameter int DW    = XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_push_live,
  input  logic [AW-1:0]            i_push_addr,
  input  logic [DW-1:0]            i_push_data,
  input  logic                     i_pop,
  input  logic                     i_kill,
  input  logic [AW-1:0]            i_kill_addr,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_head_live,
  output logic [AW-1:0]            o_head_addr,
  output logic [DW-1:0]            o_head_data,
  output logic [2**AW-1:0]         o_pending
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   r_wr;
  logic [PW:0]   r_rd;
  logic          r_live [DEPTH];
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];

  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_rd_idx;

  assign w_wr_idx    = r_wr[PW-1:0];
  assign w_rd_idx    = r_rd[PW-1:0];
  assign o_empty     = (r_wr == r_rd);
  assign o_count     = r_wr - r_rd;
  assign o_head_live = r_live[w_rd_idx];
  assign o_head_addr = r_addr[w_rd_idx];
  assign o_head_data = r_data[w_rd_idx];

  // Live bits are cleared on pop so the bitmap only needs to scan live flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_live[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill && (r_addr[i] == i_kill_addr)) r_live[i] <= 1'b0;
      end
      if (i_pop) begin
        r_live[w_rd_idx] <= 1'b0;
        r_rd             <= r_rd + 1'b1;
      end
      if (i_push) begin
        r_live[w_wr_idx] <= i_push_live && !(i_kill && (i_push_addr == i_kill_addr));
        r_wr             <= r_wr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[w_wr_idx] <= i_push_addr;
      r_data[w_wr_idx] <= i_push_data;
    end
  end

  always_comb begin
    o_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) o_pending[r_addr[i]] = 1'b1;
    end
    o_pending[0] = 1'b0;
  end
endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regfile_write_arbiter                                             |
// | Desc   : Single register-file write port merging pipeline writeback        |
// |          (strict priority) with buffered multi-cycle results.              |
// |          Optional macro REGFILE_WB_BYPASS_EN: empty-FIFO mc bypass.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int ADDRESS_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH    = XLEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_we_i,
  input  logic [ADDRESS_WIDTH-1:0]    wb_addr_i,
  input  logic [DATA_WIDTH-1:0]       wb_data_i,
  input  logic                        mc_valid_i,
  output logic                        mc_ready_o,
  input  logic [ADDRESS_WIDTH-1:0]    mc_addr_i,
  input  logic [DATA_WIDTH-1:0]       mc_data_i,
  output logic                        rf_we_o,
  output logic [ADDRESS_WIDTH-1:0]    rf_addr_o,
  output logic [DATA_WIDTH-1:0]       rf_wd_o,
  output logic [2**ADDRESS_WIDTH-1:0] pending_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] c_FIFO_DEPTH = (PW+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] c_X0 = ADDRESS_WIDTH'(REG_ZERO);

  logic                     w_wb_eff;
  logic                     w_mc_xfer;
  logic                     w_mc_nz;
  logic                     w_bypass;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fifo_empty;
  logic [PW:0]              w_fifo_count;
  logic                     w_head_live;
  logic [ADDRESS_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0]    w_head_data;

  assign mc_ready_o = (w_fifo_count < c_FIFO_DEPTH);
  assign w_wb_eff   = wb_we_i && (wb_addr_i != c_X0);
  assign w_mc_xfer  = mc_valid_i && mc_ready_o;
  assign w_mc_nz    = (mc_addr_i != c_X0);

`ifdef REGFILE_WB_BYPASS_EN
  assign w_bypass = w_mc_xfer && w_mc_nz && w_fifo_empty && !w_wb_eff;
`else
  assign w_bypass = 1'b0;
`endif

  // x0 transfers are accepted but dropped here.
  assign w_push = w_mc_xfer && w_mc_nz && !w_bypass;
  assign w_pop  = !w_wb_eff && !w_fifo_empty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (ADDRESS_WIDTH),
    .DW    (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_live (1'b1),
    .i_push_addr (mc_addr_i),
    .i_push_data (mc_data_i),
    .i_pop       (w_pop),
    .i_kill      (w_wb_eff),
    .i_kill_addr (wb_addr_i),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count),
    .o_head_live (w_head_live),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_pending   (pending_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_o   <= 1'b0;
      rf_addr_o <= '0;
      rf_wd_o   <= '0;
    end else if (w_wb_eff) begin
      rf_we_o   <= 1'b1;
      rf_addr_o <= wb_addr_i;
      rf_wd_o   <= wb_data_i;
    end else if (w_pop) begin
      rf_we_o   <= w_head_live;
      rf_addr_o <= w_head_addr;
      rf_wd_o   <= w_head_data;
    end else if (w_bypass) begin
      rf_we_o   <= 1'b1;
      rf_addr_o <= mc_addr_i;
      rf_wd_o   <= mc_data_i;
    end else begin
      rf_we_o   <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_regfile_write_arbiter                                          |
// | Desc   : Directed + random bench against a queue-based reference model.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_regfile_write_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        mc_valid_i = 1'b0;
  logic        mc_ready_o;
  logic [4:0]  mc_addr_i = '0;
  logic [31:0] mc_data_i = '0;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_wd_o;
  logic [31:0] pending_o;

  regfile_write_arbiter #(.DEPTH(DEPTH), .ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .mc_valid_i(mc_valid_i), .mc_ready_o(mc_ready_o),
    .mc_addr_i(mc_addr_i), .mc_data_i(mc_data_i),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_wd_o(rf_wd_o),
    .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          live;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        exp_we = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_wd = '0;
  int          n_checks = 0;
  int          n_err = 0;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (q[i]) if (q[i].live) p[q[i].addr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".we"},      64'(rf_we_o),    64'(exp_we));
    chk({tag, ".addr"},    64'(rf_addr_o),  64'(exp_addr));
    chk({tag, ".wd"},      64'(rf_wd_o),    64'(exp_wd));
    chk({tag, ".ready"},   64'(mc_ready_o), 64'(q.size() < DEPTH));
    chk({tag, ".pending"}, 64'(pending_o),  64'(model_pending()));
  endtask

  // Advance one clock: evaluate the arbitration rules on the current inputs,
  // then compare DUT outputs shortly after the edge.
  task automatic cycle(input string tag);
    bit   wbe, xfer, byp;
    ent_t e;
    wbe  = wb_we_i && (wb_addr_i != 0);
    xfer = mc_valid_i && (q.size() < DEPTH);
    byp  = BYPASS && xfer && (mc_addr_i != 0) && (q.size() == 0) && !wbe;
    if (wbe) foreach (q[i]) if (q[i].addr == wb_addr_i) q[i].live = 1'b0;
    if (wbe) begin
      exp_we = 1'b1; exp_addr = wb_addr_i; exp_wd = wb_data_i;
    end else if (q.size() != 0) begin
      e = q.pop_front();
      exp_we = e.live; exp_addr = e.addr; exp_wd = e.data;
    end else if (byp) begin
      exp_we = 1'b1; exp_addr = mc_addr_i; exp_wd = mc_data_i;
    end else begin
      exp_we = 1'b0;
    end
    if (xfer && (mc_addr_i != 0) && !byp) begin
      e.live = !(wbe && (wb_addr_i == mc_addr_i));
      e.addr = mc_addr_i;
      e.data = mc_data_i;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle_in();
    wb_we_i = 1'b0; mc_valid_i = 1'b0;
  endtask

  initial begin
    // Reset and idle
    #12 rst = 1'b0;
    chk("rst.we", 64'(rf_we_o), 64'd0);
    chk("rst.addr", 64'(rf_addr_o), 64'd0);
    chk("rst.ready", 64'(mc_ready_o), 64'd1);
    chk("rst.pending", 64'(pending_o), 64'd0);
    for (int i = 0; i < 3; i++) cycle("idle");
    chk("idle.we", 64'(rf_we_o), 64'd0);

    // Pipeline write, then x0 write
    wb_we_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
    cycle("wb");
    chk("wb.we", 64'(rf_we_o), 64'd1);
    chk("wb.addr", 64'(rf_addr_o), 64'd5);
    chk("wb.wd", 64'(rf_wd_o), 64'hDEADBEEF);
    wb_addr_i = 5'd0; wb_data_i = 32'h12345678;
    cycle("wbx0");
    chk("wbx0.we", 64'(rf_we_o), 64'd0);
    idle_in();
    cycle("idle");

    // Fill under continuous pipeline writes, then drain
    for (int i = 1; i <= 4; i++) begin
      wb_we_i = 1'b1; wb_addr_i = 5'd20; wb_data_i = 32'hA000_0000 + i;
      mc_valid_i = 1'b1; mc_addr_i = 5'(i); mc_data_i = 32'hC000_0000 + i;
      cycle("fill");
    end
    chk("fill.ready", 64'(mc_ready_o), 64'd0);
    chk("fill.pending", 64'(pending_o), 64'h1E);
    mc_valid_i = 1'b0;
    cycle("fill.hold");
    wb_we_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle("drain");
      chk("drain.we", 64'(rf_we_o), 64'd1);
      chk("drain.addr", 64'(rf_addr_o), 64'(i));
    end
    cycle("drain.end");
    chk("drain.end.we", 64'(rf_we_o), 64'd0);

    // WAW kill: entry enqueued while FIFO is held busy, then overwritten
    wb_we_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h33;
    mc_valid_i = 1'b1; mc_addr_i = 5'd7; mc_data_i = 32'h11;
    cycle("waw.enq");
    chk("waw.pend7", 64'(pending_o[7]), 64'd1);
    mc_valid_i = 1'b0; wb_addr_i = 5'd7; wb_data_i = 32'h22;
    cycle("waw.kill");
    chk("waw.kill.wd", 64'(rf_wd_o), 64'h22);
    chk("waw.pend7c", 64'(pending_o[7]), 64'd0);
    idle_in();
    cycle("waw.dead");
    chk("waw.dead.we", 64'(rf_we_o), 64'd0);
    cycle("idle");

    // Same-cycle mc and pipeline write to x7
    wb_we_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h22;
    mc_valid_i = 1'b1; mc_addr_i = 5'd7; mc_data_i = 32'h11;
    cycle("waw2");
    chk("waw2.wd", 64'(rf_wd_o), 64'h22);
    chk("waw2.pend", 64'(pending_o), 64'd0);
    idle_in();
    cycle("waw2.dead");
    chk("waw2.dead.we", 64'(rf_we_o), 64'd0);
    cycle("idle");

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      wb_we_i = 1'b1; wb_addr_i = 5'd30; wb_data_i = 32'(i);
      mc_valid_i = 1'b1; mc_addr_i = 5'(10 + i); mc_data_i = 32'hB0 + i;
      cycle("pre_rst");
    end
    idle_in();
    rst = 1'b1;
    #2;
    chk("mrst.we", 64'(rf_we_o), 64'd0);
    chk("mrst.ready", 64'(mc_ready_o), 64'd1);
    chk("mrst.pending", 64'(pending_o), 64'd0);
    rst = 1'b0;
    q.delete(); exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    for (int i = 0; i < 3; i++) begin
      cycle("post_rst");
      chk("post_rst.we", 64'(rf_we_o), 64'd0);
    end

    // Latency of a lone mc result on an empty FIFO
    mc_valid_i = 1'b1; mc_addr_i = 5'd9; mc_data_i = 32'h99;
    cycle("lat1");
    chk("lat1.we", 64'(rf_we_o), 64'(BYPASS));
    mc_valid_i = 1'b0;
    cycle("lat2");
    chk("lat2.we", 64'(rf_we_o), 64'(!BYPASS));
    cycle("idle");

    // Randomized traffic over a small register range to provoke kills and x0
    for (int i = 0; i < 400; i++) begin
      wb_we_i    = ($urandom_range(0, 2) == 0);
      wb_addr_i  = 5'($urandom_range(0, 7));
      wb_data_i  = $urandom;
      mc_valid_i = ($urandom_range(0, 1) == 1);
      mc_addr_i  = 5'($urandom_range(0, 7));
      mc_data_i  = $urandom;
      cycle("rand");
    end
    idle_in();
    for (int i = 0; i < 6; i++) cycle("flush");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Single-writer front end for the CPU register file's write port. Merges the in-order pipeline writeback stream with results from multi-cycle units (divider, outstanding loads) into the one write port. Buffers multi-cycle results in a small FIFO and gives the pipeline writeback strict priority. Drives the register file's write address, data and enable from registered outputs, and exports a pending-destination bitmap for the hazard unit.

## Interface
- `DEPTH`, 4: multi-cycle result FIFO entries; power of two, ≥ 2.
- `ADDRESS_WIDTH`, 5: register address width.
- `DATA_WIDTH`, 32: register data width.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wb_we_i` in 1: pipeline writeback valid; cannot be stalled.
- `wb_addr_i` in ADDRESS_WIDTH: pipeline destination register.
- `wb_data_i` in DATA_WIDTH: pipeline result.
- `mc_valid_i` in 1: multi-cycle result valid.
- `mc_ready_o` out 1: FIFO can accept a multi-cycle result.
- `mc_addr_i` in ADDRESS_WIDTH: multi-cycle destination register.
- `mc_data_i` in DATA_WIDTH: multi-cycle result.
- `rf_we_o` out 1: register file write enable.
- `rf_addr_o` out ADDRESS_WIDTH: register file write address.
- `rf_wd_o` out DATA_WIDTH: register file write data.
- `pending_o` out 2**ADDRESS_WIDTH: bit r set while a live FIFO entry targets register r.

## Operation
- **Write qualification.** A pipeline write is effective when `wb_we_i` is high and `wb_addr_i` ≠ 0. An mc transfer happens when `mc_valid_i` and `mc_ready_o` are both high.
- **Register x0.**
  - Transfers to x0 are accepted but never enqueued.
  - Effective pipeline writes to x0 never occur.
- **FIFO entries.** Each entry holds {live, addr, data}.
  - An mc transfer enqueues an entry with live = 1.
- **Priority.** In a cycle with an effective pipeline write:
  - The output register loads the pipeline write.
  - The FIFO does not pop.
- **Drain.** In a cycle with no effective pipeline write and a non-empty FIFO:
  - The head is popped into the output register.
  - `rf_we_o` = head.live.
  - Dead entries consume their drain cycle with `rf_we_o` = 0.
- **Idle.** In a cycle with neither an effective pipeline write nor a pop, `rf_we_o` loads 0. Address and data hold their previous values.
- **WAW kill.** An effective pipeline write to register A clears `live` on every FIFO entry with addr A.
  - A same-cycle mc transfer to A is enqueued dead. The pipeline write is defined as newer.
- **Pending bitmap.** `pending_o` is the OR of one-hot(addr) over live entries, computed combinationally from FIFO state. Bit 0 is always 0.
- **Backpressure.** `mc_ready_o` = (count < DEPTH), from registered count only.
  - A pop in the same cycle does not raise ready while the FIFO is full.
- **Pointers.** Read and write pointers are log2(DEPTH)+1 bits with a wrap bit.
  - Full: indices equal, wrap bits differ.
  - Empty: pointers equal.
- **Simultaneous push and pop.** Count is unchanged. This is legal at any fill level below full.
- **Reset.** Asserting `rst`, including mid-operation, empties the FIFO and discards all queued results.
  - Reset values: `rf_we_o` = 0, `rf_addr_o` = 0, `rf_wd_o` = 0, `mc_ready_o` = 1, `pending_o` = 0.

## Timing
- All write-port outputs are registered.
- The register file samples them on the following falling edge, half a cycle after the rising edge that loads them.
- Pipeline write latency: 1 cycle from `wb_we_i` sampled to `rf_we_o` high.
- Multi-cycle latency: minimum 2 cycles (enqueue edge, then drain edge) with the bypass option disabled.
  - Each intervening pipeline write adds 1 cycle.
- Throughput: one register file write per cycle. The FIFO drains at one entry per cycle without pipeline writes.
- `pending_o` updates on the edge of enqueue, pop or kill.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined: an mc transfer that arrives with the FIFO empty and no effective pipeline write bypasses the FIFO.
  - It loads the output register directly, giving latency 1.
  - `pending_o` is not set for it.
- `REGFILE_WB_BYPASS_EN` undefined: every mc transfer to a non-zero register is enqueued. Minimum latency is 2.

## Structure
- Shared package `rf_pkg`:
  - `REG_ADDR_W` = 5
  - `XLEN` = 32
  - `REG_ZERO` = 5'd0
  - typedef `wb_entry_t` {logic live; logic [REG_ADDR_W-1:0] addr; logic [XLEN-1:0] data}
- One sub-module, `wb_fifo`: the entry storage with pointers, count and a per-entry kill-by-address port.
- Arbitration, bypass and the output register live in `regfile_write_arbiter`.

## Test plan
- **Reset.** Reset, then idle 3 cycles → `rf_we_o` = 0, `mc_ready_o` = 1, `pending_o` = 0.
- **Pipeline write.** `wb_we_i` = 1, addr 5, data 0xDEADBEEF for 1 cycle → next cycle `rf_we_o` = 1, `rf_addr_o` = 5, `rf_wd_o` = 0xDEADBEEF; x0 write → `rf_we_o` = 0.
- **Fill and drain.**
  - Hold pipeline writes every cycle while pushing 4 mc results (addr 1–4) → `mc_ready_o` = 0 after the 4th; `pending_o` = 0x1E.
  - Release pipeline writes → writes 1, 2, 3, 4 on consecutive cycles.
- **WAW kill.**
  - Enqueue mc addr 7 = 0x11, then pipeline write addr 7 = 0x22 → only 0x22 is written; the dead entry yields one `rf_we_o` = 0 drain cycle; `pending_o[7]` clears.
  - Same-cycle mc and pipeline writes to addr 7 give the same result.
- **Reset mid-drain.** Pulse `rst` with 3 entries queued → no further writes; `pending_o` = 0; `mc_ready_o` = 1.
- **Bypass.** With `REGFILE_WB_BYPASS_EN`, mc addr 9 on an empty FIFO → `rf_we_o` next cycle; without it, two cycles later.
